ntt_bank_reader: RTL and testbench
==================================

// Module: ntt_bank_reader
// PURPOSE
//  Result-unload engine for the 4-bank mixed-radix NTT core. Once the core
//  finishes (done_flag), this block reads the coefficient memory bank_0..bank_3
//  and streams it out one coefficient per beat, in natural order, on a
//  valid/ready interface. It is the drain side of the bank memory that the
//  preload path fills. It sits beside top_stage and shares the bank read port
//  through the core's idle-time mux.
// PARAMETERS
//  DATA_W  12  coefficient width in bits (one bank word)
//  ADDR_W   6  bank address width; DEPTH = 2**ADDR_W words per bank
//  (bank count is fixed at 4; coefficient index = addr*4 + bank)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous reset, active-low (0 = reset)
//  start      in   1          begin unload; sampled only in IDLE
//  clr        in   1          synchronous abort, any state
//  rd_en      out  1          bank read strobe, same for all 4 banks
//  rd_addr    out  ADDR_W     bank read address, same for all 4 banks
//  rd_data_0  in   DATA_W     bank_0 read data, valid 1 cycle after rd_en
//  rd_data_1  in   DATA_W     bank_1 read data, valid 1 cycle after rd_en
//  rd_data_2  in   DATA_W     bank_2 read data, valid 1 cycle after rd_en
//  rd_data_3  in   DATA_W     bank_3 read data, valid 1 cycle after rd_en
//  out_data   out  DATA_W     streamed coefficient
//  out_valid  out  1          out_data valid
//  out_ready  in   1          downstream accepts beat (transfer = valid&ready)
//  out_last   out  1          marks coefficient index 4*DEPTH-1
//  busy       out  1          high in every state except IDLE
//  done       out  1          1-cycle pulse after the final transfer
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE. addr=0, sel=0. All outputs 0. Buffer cleared.
//  FSM: IDLE -> RD -> CAP -> EMIT -> (RD | FIN) -> IDLE
//   IDLE: start=1 at an edge -> RD. start in any other state is ignored.
//   RD  : rd_en=1, rd_addr=addr, for one cycle -> CAP.
//   CAP : latch rd_data_0..3 into buf[0..3] at the end of the cycle. sel=0. -> EMIT.
//   EMIT: out_valid=1, out_data=buf[sel].
//         On a transfer: sel<3 -> sel++. sel==3 & addr<DEPTH-1 -> addr++, RD.
//         sel==3 & addr==DEPTH-1 -> FIN.
//   FIN : done=1 for exactly one cycle, addr=0 -> IDLE.
//  Timing: first out_valid is 3 cycles after start is sampled.
//   Each address group costs 2 + 4 cycles with out_ready held high.
//   One full unload costs 6*DEPTH + 1 cycles.
//  Handshake: once out_valid is high, out_valid, out_data and out_last stay
//   stable until a transfer. out_valid never drops without a transfer,
//   except on clr or reset.
//  out_last = EMIT & sel==3 & addr==DEPTH-1.
//  Widths: addr is ADDR_W bits and is only incremented below DEPTH-1, so it
//   never wraps. sel is 2 bits.
//  rd_en is 0 outside RD. rd_addr holds its last value and is don't-care
//   when rd_en=0.
//  clr=1: the next state is IDLE, addr=sel=0, out_valid=0, and no done pulse.
//   clr has priority over start and over a transfer in the same cycle.
//  Reset mid-unload: outputs are 0 immediately. A new start restarts at index 0.
//  start and clr in the same IDLE cycle: clr wins and the block stays IDLE.
// TESTING
//  1 Preload bank b[a]=4a+b, DEPTH=64, out_ready=1, pulse start -> 256 beats with
//    out_data 0..255 in order, out_last only on 255, done 1 cycle later, 385 cycles total.
//  2 Same preload, out_ready toggling 1,0,0,1 (random seed 7) -> same 0..255
//    sequence, out_data stable whenever valid&!ready, no beat duplicated or lost.
//  3 Assert clr during EMIT at index 130 -> out_valid=0 next cycle, no done.
//    A restart then streams from 0.
//  4 Drop rst to 0 mid-unload at index 77 -> all outputs 0 asynchronously.
//    After release plus start, a full 0..255 stream follows.
//  5 Pulse start while busy (index 40) -> ignored, stream continues unchanged.
//    start and clr together in IDLE -> stays IDLE, busy=0.
//  6 Checker on rd_en/rd_addr: exactly 64 strobes per unload, addresses 0..63
//    ascending, rd_en never high outside RD.

Source files
------------

// File: rtl/ntt_bank_reader_if.sv
// Bank read port and coefficient stream bundle for the NTT result unloader.
// The master side (the unloader) drives the bank read strobe/address and the
// output stream. The slave side (bank memory plus downstream sink) returns
// read data and backpressure.
interface ntt_bank_reader_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 6
);
  // Bank read port, shared by all four banks
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data_0;
  logic [DATA_W-1:0] rd_data_1;
  logic [DATA_W-1:0] rd_data_2;
  logic [DATA_W-1:0] rd_data_3;

  // Coefficient stream, valid/ready
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data_0,
    input  rd_data_1,
    input  rd_data_2,
    input  rd_data_3,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data_0,
    output rd_data_1,
    output rd_data_2,
    output rd_data_3,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );
endinterface

// File: rtl/ntt_bank_reader.sv
// Result-unload engine for the 4-bank NTT core. After the core finishes, it
// reads the four coefficient banks one address group at a time and streams
// the coefficients out in natural order (index = addr*4 + bank) on a
// valid/ready interface. Every output is a register loaded from the
// next-state values, so downstream sees no combinational paths from inputs.
module ntt_bank_reader #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                clr_i,
  output logic                busy_o,
  output logic                done_o,
  ntt_bank_reader_if.master   bus
);

  // Last word address of each bank (DEPTH-1)
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]        SEL_LAST  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_EMIT = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  // Control state
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [1:0]        sel_q,   sel_d;
  logic [DATA_W-1:0] cbuf_q [4];
  logic [DATA_W-1:0] cbuf_d [4];

  // Registered outputs
  logic              rd_en_q,     rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q,  out_last_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;

  // A beat leaves only while we are presenting it and the sink takes it
  logic xfer_s;
  assign xfer_s = (state_q == S_EMIT) & out_valid_q & bus.out_ready;

  // State and datapath registers, async reset clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= ADDR_ZERO;
      sel_q     <= 2'd0;
      cbuf_q[0] <= {DATA_W{1'b0}};
      cbuf_q[1] <= {DATA_W{1'b0}};
      cbuf_q[2] <= {DATA_W{1'b0}};
      cbuf_q[3] <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      cbuf_q[0] <= cbuf_d[0];
      cbuf_q[1] <= cbuf_d[1];
      cbuf_q[2] <= cbuf_d[2];
      cbuf_q[3] <= cbuf_d[3];
    end
  end

  // Next-state logic: clr aborts from any state and beats start and transfers
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    cbuf_d[0] = cbuf_q[0];
    cbuf_d[1] = cbuf_q[1];
    cbuf_d[2] = cbuf_q[2];
    cbuf_d[3] = cbuf_q[3];
    if (clr_i) begin
      state_d = S_IDLE;
      addr_d  = ADDR_ZERO;
      sel_d   = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_RD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RD: begin
          state_d = S_CAP;
        end
        S_CAP: begin
          // Bank data returns one cycle after the strobe
          cbuf_d[0] = bus.rd_data_0;
          cbuf_d[1] = bus.rd_data_1;
          cbuf_d[2] = bus.rd_data_2;
          cbuf_d[3] = bus.rd_data_3;
          sel_d     = 2'd0;
          state_d   = S_EMIT;
        end
        S_EMIT: begin
          if (xfer_s) begin
            if (sel_q != SEL_LAST) begin
              sel_d   = sel_q + 2'd1;
              state_d = S_EMIT;
            end else if (addr_q != ADDR_LAST) begin
              // addr only advances below the last word, so it never wraps
              addr_d  = addr_q + ADDR_ONE;
              state_d = S_RD;
            end else begin
              state_d = S_FIN;
            end
          end else begin
            state_d = S_EMIT;
          end
        end
        S_FIN: begin
          addr_d  = ADDR_ZERO;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          addr_d  = ADDR_ZERO;
          sel_d   = 2'd0;
        end
      endcase
    end
  end

  // Output decode from next-state values so the output registers line up with state_q
  always_comb begin
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    out_data_d  = {DATA_W{1'b0}};
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_RD: begin
        busy_d    = 1'b1;
        rd_en_d   = 1'b1;
        rd_addr_d = addr_d;
      end
      S_CAP: begin
        busy_d = 1'b1;
      end
      S_EMIT: begin
        busy_d      = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = cbuf_d[sel_d];
        out_last_d  = (sel_d == SEL_LAST) & (addr_d == ADDR_LAST);
      end
      S_FIN: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Output registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q     <= 1'b0;
      rd_addr_q   <= ADDR_ZERO;
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_ntt_bank_reader.sv
// Directed/randomized bench for ntt_bank_reader: a bank RAM model with one
// cycle read latency, a reference stream built from the bank contents by
// coefficient index, and per-cycle handshake/read-port checks.
module tb_ntt_bank_reader;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int NCOEF  = 4 * DEPTH;

  logic clk = 1'b0;
  logic rst_n;
  logic start_i;
  logic clr_i;
  logic busy_o;
  logic done_o;

  ntt_bank_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ntt_bank_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .clr_i   (clr_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Bank memories and their synchronous read port
  logic [DATA_W-1:0] mem [4][DEPTH];
  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) begin
      bus.rd_data_0 <= mem[0][bus.rd_addr];
      bus.rd_data_1 <= mem[1][bus.rd_addr];
      bus.rd_data_2 <= mem[2][bus.rd_addr];
      bus.rd_data_3 <= mem[3][bus.rd_addr];
    end
  end

  logic [DATA_W-1:0] exp_q [NCOEF];
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bank b word a holds coefficient 4a+b, so the stream should count 0..255
  task automatic preload_ramp();
    for (int a = 0; a < DEPTH; a++)
      for (int b = 0; b < 4; b++)
        mem[b][a] = DATA_W'(4 * a + b);
    for (int i = 0; i < NCOEF; i++) exp_q[i] = DATA_W'(i);
  endtask

  // Random bank contents; expected stream is coefficient i = bank i%4, word i/4
  task automatic preload_random();
    for (int a = 0; a < DEPTH; a++)
      for (int b = 0; b < 4; b++)
        mem[b][a] = DATA_W'($urandom);
    for (int i = 0; i < NCOEF; i++) exp_q[i] = mem[i % 4][i / 4];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_data"},  32'(bus.out_data),  32'd0);
    chk({tag, "_last"},  32'(bus.out_last),  32'd0);
    chk({tag, "_rd_en"}, 32'(bus.rd_en),     32'd0);
    chk({tag, "_busy"},  32'(busy_o),        32'd0);
    chk({tag, "_done"},  32'(done_o),        32'd0);
  endtask

  // One unload. mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: random ready.
  // abort_at / rst_at / poke_at name a coefficient index (-1 = unused).
  task automatic unload(input int mode, input int abort_at, input int rst_at, input int poke_at);
    int idx;
    int nrd;
    int cyc;
    int pat;
    logic rdy;
    logic prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic prev_last;
    logic fin;
    idx = 0; nrd = 0; cyc = 0; pat = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; fin = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 1;
    chk("start_busy", 32'(busy_o), 32'd1);
    while (!fin && cyc < 4000) begin
      if (bus.rd_en === 1'b1) begin
        chk("rd_addr", 32'(bus.rd_addr), 32'(nrd));
        chk("rd_vs_valid", 32'(bus.out_valid), 32'd0);
        nrd++;
      end
      if (cyc == 3) chk("first_valid", 32'(bus.out_valid), 32'd1);
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_data",  32'(bus.out_data),  32'(prev_data));
        chk("stall_last",  32'(bus.out_last),  32'(prev_last));
      end
      if (done_o === 1'b1) begin
        chk("done_beats",   32'(idx), 32'(NCOEF));
        chk("rd_strobes",   32'(nrd), 32'(DEPTH));
        chk("done_novalid", 32'(bus.out_valid), 32'd0);
        if (mode == 0) chk("cycles", 32'(cyc), 32'd385);
        fin = 1'b1;
      end else begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = ((pat % 4) == 0) || ((pat % 4) == 3);
          default: rdy = 1'($urandom_range(1, 0));
        endcase
        pat++;
        bus.out_ready = rdy;
        if (bus.out_valid === 1'b1 && idx == abort_at) begin
          clr_i = 1'b1;
          bus.out_ready = 1'b1;
          tick();
          clr_i = 1'b0;
          chk("clr_valid", 32'(bus.out_valid), 32'd0);
          chk("clr_busy",  32'(busy_o),        32'd0);
          chk("clr_done",  32'(done_o),        32'd0);
          for (int k = 0; k < 4; k++) begin
            tick();
            chk("clr_no_done", 32'(done_o), 32'd0);
            chk("clr_idle",    32'(busy_o), 32'd0);
          end
          return;
        end
        if (bus.out_valid === 1'b1 && idx == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk_all_zero("async_rst");
          tick();
          tick();
          rst_n = 1'b1;
          tick();
          chk_all_zero("post_rst");
          return;
        end
        if (bus.out_valid === 1'b1 && idx == poke_at) start_i = 1'b1;
        if (bus.out_valid === 1'b1 && rdy) begin
          chk("beat_data", 32'(bus.out_data), 32'(exp_q[idx]));
          chk("beat_last", 32'(bus.out_last), 32'(idx == NCOEF - 1));
          idx++;
        end
        prev_stall = (bus.out_valid === 1'b1) && !rdy;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
        tick();
        start_i = 1'b0;
        cyc++;
      end
    end
    chk("finished", 32'(fin), 32'd1);
    tick();
    chk("done_pulse", 32'(done_o),        32'd0);
    chk("end_idle",   32'(busy_o),        32'd0);
    chk("end_valid",  32'(bus.out_valid), 32'd0);
    chk("end_rd_en",  32'(bus.rd_en),     32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    clr_i = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_all_zero("idle");

    // Full unload, ready held high
    preload_ramp();
    unload(0, -1, -1, -1);
    // Backpressure pattern
    unload(1, -1, -1, -1);
    // Abort at 130 then restart from 0
    unload(0, 130, -1, -1);
    unload(0, -1, -1, -1);
    // Reset at 77 then full restart
    unload(2, -1, 77, -1);
    unload(0, -1, -1, -1);
    // start while busy is ignored
    unload(0, -1, -1, 40);

    // start and clr together in IDLE: stays idle
    start_i = 1'b1;
    clr_i = 1'b1;
    tick();
    start_i = 1'b0;
    clr_i = 1'b0;
    chk("startclr_busy",  32'(busy_o),    32'd0);
    chk("startclr_rd_en", 32'(bus.rd_en), 32'd0);
    tick();
    chk("startclr_busy2", 32'(busy_o),    32'd0);

    // Random bank contents with random backpressure
    preload_random();
    unload(2, -1, -1, -1);
    unload(1, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
